// File: rtl/noc_pkg.sv
// Shared mesh-router definitions: flit type codes, type-field width, input-port FSM
// states, debug view and the default destination-to-output routing map.
package noc_pkg;

    localparam logic [1:0] BODY     = 2'b00;
    localparam logic [1:0] HEAD     = 2'b01;
    localparam logic [1:0] TAIL     = 2'b10;
    localparam logic [1:0] HEADTAIL = 2'b11;

    // The type field occupies the top TYPE_W bits of every flit.
    localparam int TYPE_W = 2;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_GRANT = 2'd1,
        FORWARD    = 2'd2,
        RELEASE    = 2'd3
    } ipc_state_t;

    typedef struct packed {
        ipc_state_t  state;
        logic        fifo_full;
        logic        fifo_empty;
        logic [7:0]  fifo_count;
    } ipc_dbg_t;

    function automatic logic [63:0] default_route_table(input int n, input int outputs);
        int rw;
        rw = (outputs > 1) ? $clog2(outputs) : 1;
        default_route_table = '0;
        for (int d = 0; d < n; d++) begin
            default_route_table = default_route_table | (64'(d % outputs) << (d * rw));
        end
    endfunction

    function automatic logic is_head_type(input logic [1:0] t);
        return (t == HEAD) || (t == HEADTAIL);
    endfunction

    function automatic logic is_last_type(input logic [1:0] t);
        return (t == TAIL) || (t == HEADTAIL);
    endfunction

endpackage

// File: rtl/input_port_controller_if.sv
// Bundle between one router input port controller, its upstream link and the
// switch control unit / crossbar.
interface input_port_controller_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int REQUEST_WIDTH = 2
);
    // Flit handshakes: a flit moves on a clock edge where valid and ready are both
    // high; valid never depends combinationally on ready, data is stable while valid.
    logic [DATA_WIDTH-1:0]    dataIn;
    logic                     validIn;
    logic                     readyIn;
    logic [DATA_WIDTH-1:0]    dataOut;
    logic                     validOut;
    logic                     readyOut;
    logic                     routeReserveRequestValid;
    logic [REQUEST_WIDTH-1:0] routeReserveRequest;
    logic                     routeReserveStatus;
    logic                     PortReserved;
    logic                     routeRelieve;

    modport slave (
        input  dataIn, validIn, readyOut, routeReserveStatus, PortReserved,
        output readyIn, dataOut, validOut, routeReserveRequestValid,
               routeReserveRequest, routeRelieve
    );

    modport master (
        output dataIn, validIn, readyOut, routeReserveStatus, PortReserved,
        input  readyIn, dataOut, validOut, routeReserveRequestValid,
               routeReserveRequest, routeRelieve
    );

endinterface

// File: rtl/flit_fifo.sv
// Power-of-two flit buffer with valid/ready on both sides; the head flit is
// presented on rd_data whenever the buffer is not empty.
module flit_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    localparam int PTR_W = $clog2(FIFO_DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  full,
    output logic                  empty,
    output logic [CNT_W-1:0]      count
);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  wr_fire;
    logic                  rd_fire;

    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign wr_ready = !full;
    assign rd_valid = !empty;
    assign rd_data  = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign wr_fire  = wr_valid && wr_ready;
    assign rd_fire  = rd_valid && rd_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_fire) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(wr_fire) - CNT_W'(rd_fire);
    end

    // Storage is cleared too so dataOut reads zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/input_port_controller.sv
// Router input port: buffers flits, routes the head flit, holds a path reservation
// and streams the packet to the crossbar. IPC_STATS_EN adds packet/flit counters.
module input_port_controller
    import noc_pkg::*;
#(
    parameter int N          = 4,
    parameter int OUTPUTS    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter logic [N*$clog2(OUTPUTS)-1:0] ROUTING_TABLE =
        (N*$clog2(OUTPUTS))'(default_route_table(N, OUTPUTS))
) (
    input  logic                    clk,
    input  logic                    rst,
    input_port_controller_if.slave  bus,
    output ipc_dbg_t                dbg
`ifdef IPC_STATS_EN
    ,
    output logic [15:0]             packetCount,
    output logic [15:0]             flitCount
`endif
);

    localparam int DEST_W        = $clog2(N);
    localparam int REQUEST_WIDTH = $clog2(OUTPUTS);
    localparam int CNT_W         = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_WIDTH-1:0]    fifo_rd_data;
    logic                     fifo_nonempty;
    logic                     fifo_rd_ready;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [CNT_W-1:0]         fifo_count;

    logic [TYPE_W-1:0]        head_type;
    logic [DEST_W-1:0]        head_dest;
    logic [REQUEST_WIDTH-1:0] head_port;
    logic                     valid_out;
    logic                     xfer;
    logic                     discard;

    ipc_state_t               state_q, state_d;
    logic                     req_valid_q, req_valid_d;
    logic [REQUEST_WIDTH-1:0] req_port_q, req_port_d;
    logic                     relieve_q, relieve_d;

    flit_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (bus.dataIn),
        .wr_valid (bus.validIn),
        .wr_ready (bus.readyIn),
        .rd_data  (fifo_rd_data),
        .rd_valid (fifo_nonempty),
        .rd_ready (fifo_rd_ready),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign head_type = fifo_rd_data[DATA_WIDTH-1 -: TYPE_W];
    assign head_dest = fifo_rd_data[DEST_W-1:0];
    assign head_port = ROUTING_TABLE[int'(head_dest)*REQUEST_WIDTH +: REQUEST_WIDTH];

    assign valid_out     = (state_q == FORWARD) && fifo_nonempty && bus.PortReserved;
    assign xfer          = valid_out && bus.readyOut;
    // Anything but a head flit reaching the front while idle is an orphan; drop it.
    assign discard       = (state_q == IDLE) && fifo_nonempty && !is_head_type(head_type);
    assign fifo_rd_ready = xfer || discard;

    always_comb begin
        state_d     = state_q;
        req_valid_d = req_valid_q;
        req_port_d  = req_port_q;
        relieve_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (fifo_nonempty && is_head_type(head_type)) begin
                    req_port_d  = head_port;
                    req_valid_d = 1'b1;
                    state_d     = WAIT_GRANT;
                end
            end
            WAIT_GRANT: begin
                if (bus.routeReserveStatus) begin
                    req_valid_d = 1'b0;
                    state_d     = FORWARD;
                end
            end
            FORWARD: begin
                if (xfer && is_last_type(head_type)) begin
                    relieve_d = 1'b1;
                    state_d   = RELEASE;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // req_port_q is only rewritten by the next head, so it outlives the relieve pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            req_valid_q <= 1'b0;
            req_port_q  <= '0;
            relieve_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            req_port_q  <= req_port_d;
            relieve_q   <= relieve_d;
        end
    end

    assign bus.dataOut                  = fifo_rd_data;
    assign bus.validOut                 = valid_out;
    assign bus.routeReserveRequestValid = req_valid_q;
    assign bus.routeReserveRequest      = req_port_q;
    assign bus.routeRelieve             = relieve_q;

    assign dbg.state      = state_q;
    assign dbg.fifo_full  = fifo_full;
    assign dbg.fifo_empty = fifo_empty;
    assign dbg.fifo_count = 8'(fifo_count);

`ifdef IPC_STATS_EN
    logic [15:0] packet_count_q, packet_count_d;
    logic [15:0] flit_count_q, flit_count_d;

    always_comb begin
        packet_count_d = packet_count_q;
        flit_count_d   = flit_count_q;
        if (relieve_q && (packet_count_q != 16'hFFFF)) begin
            packet_count_d = packet_count_q + 16'd1;
        end
        if (xfer && (flit_count_q != 16'hFFFF)) begin
            flit_count_d = flit_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            packet_count_q <= '0;
            flit_count_q   <= '0;
        end else begin
            packet_count_q <= packet_count_d;
            flit_count_q   <= flit_count_d;
        end
    end

    assign packetCount = packet_count_q;
    assign flitCount   = flit_count_q;
`endif

endmodule

// File: tb/tb_input_port_controller.sv
// Bench for input_port_controller: cycle vector table for two packets, then
// scoreboarded sequences for back-pressure, grant delay, stray flits and async reset.
module tb_input_port_controller;
  import noc_pkg::*;

  logic clk;
  logic rst;
  ipc_dbg_t dbg;
  int checks;
  int failures;
  int accepted;
  logic [7:0] src_q[$];
  logic [7:0] exp_q[$];

  input_port_controller_if #(.DATA_WIDTH(8), .REQUEST_WIDTH(2)) ipc_bus ();

`ifdef IPC_STATS_EN
  logic [15:0] packet_count;
  logic [15:0] flit_count;
`endif

  input_port_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (ipc_bus),
    .dbg (dbg)
`ifdef IPC_STATS_EN
    ,
    .packetCount (packet_count),
    .flitCount   (flit_count)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       vin;
    logic [7:0] din;
    logic       rout;
    logic       st;
    logic       pr;
    logic       rin;
    logic       vout;
    logic [7:0] dout;
    logic       rqv;
    logic [1:0] rqp;
    logic       rel;
    ipc_state_t state;
  } vec_t;

  vec_t vecs[17];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    ipc_bus.validIn            = 1'b0;
    ipc_bus.dataIn             = 8'h00;
    ipc_bus.routeReserveStatus = 1'b0;
    ipc_bus.PortReserved       = 1'b0;
    ipc_bus.readyOut           = 1'b1;
  endtask

  // Driver + switch responder + scoreboard for one packet taken from src_q/exp_q.
  task automatic run_traffic(input string name, input int grant_delay, input int ro_hold,
                             input logic [1:0] exp_port, input int stop_after);
    int wait_cnt, req_hi, port_bad, vout_early, relieve_cnt, received, acc_hold, rin_hold;
    logic status_sent, pr_on, accept, done;
    wait_cnt = 0; req_hi = 0; port_bad = 0; vout_early = 0; relieve_cnt = 0;
    received = 0; acc_hold = -1; rin_hold = -1; accepted = 0;
    status_sent = 1'b0; pr_on = 1'b0; done = 1'b0;
    for (int k = 0; k < 300; k++) begin
      ipc_bus.readyOut = (k >= ro_hold);
      ipc_bus.validIn  = (src_q.size() > 0);
      ipc_bus.dataIn   = (src_q.size() > 0) ? src_q[0] : 8'h00;
      ipc_bus.routeReserveStatus = 1'b0;
      if (ipc_bus.routeReserveRequestValid && !status_sent) begin
        wait_cnt++;
        if (wait_cnt > grant_delay) begin
          ipc_bus.routeReserveStatus = 1'b1;
          status_sent = 1'b1;
        end
      end
      ipc_bus.PortReserved = pr_on;
      #1;
      if (ro_hold > 0 && k == ro_hold) begin
        acc_hold = accepted;
        rin_hold = int'(ipc_bus.readyIn);
      end
      if (ipc_bus.routeReserveRequestValid) req_hi++;
      if (dbg.state != IDLE && ipc_bus.routeReserveRequest !== exp_port) port_bad++;
      if (ipc_bus.validOut && !ipc_bus.PortReserved) vout_early++;
      accept = ipc_bus.validIn && ipc_bus.readyIn;
      if (ipc_bus.validOut && ipc_bus.readyOut) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL %s extra_flit: got %0h expected none", name, ipc_bus.dataOut);
        end else begin
          check($sformatf("%s flit%0d", name, received), 32'(ipc_bus.dataOut), 32'(exp_q[0]));
          void'(exp_q.pop_front());
        end
        received++;
      end
      if (ipc_bus.routeRelieve) relieve_cnt++;
      tick();
      if (accept) begin
        void'(src_q.pop_front());
        accepted++;
      end
      if (ipc_bus.routeReserveStatus) pr_on = 1'b1;
      if (relieve_cnt > 0) pr_on = 1'b0;
      if (stop_after > 0 && received >= stop_after) begin
        done = 1'b1;
        break;
      end
      if (src_q.size() == 0 && exp_q.size() == 0 && relieve_cnt > 0) begin
        done = 1'b1;
        break;
      end
    end
    ipc_bus.validIn            = 1'b0;
    ipc_bus.routeReserveStatus = 1'b0;
    ipc_bus.PortReserved       = pr_on;
    #1;
    check({name, " completed"}, 32'(done), 32'd1);
    check({name, " req_cycles"}, 32'(req_hi), 32'(grant_delay + 1));
    check({name, " port_stable_bad"}, 32'(port_bad), 32'd0);
    check({name, " vout_unreserved"}, 32'(vout_early), 32'd0);
    if (ro_hold > 0) begin
      check({name, " accepted_when_full"}, 32'(acc_hold), 32'd4);
      check({name, " readyIn_when_full"}, 32'(rin_hold), 32'd0);
    end
    if (stop_after == 0) begin
      check({name, " relieve_pulses"}, 32'(relieve_cnt), 32'd1);
      check({name, " relieve_low_after"}, 32'(ipc_bus.routeRelieve), 32'd0);
      check({name, " idle_after"}, 32'(dbg.state), 32'(IDLE));
      check({name, " fifo_empty_after"}, 32'(dbg.fifo_empty), 32'd1);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    drive_idle();
    ipc_bus.readyOut = 1'b0;

    // {vin, din, rout, st, pr} -> {rin, vout, dout, rqv, rqp, rel, state} within a cycle
    vecs[0]  = '{1'b1, 8'h42, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, IDLE};
    vecs[1]  = '{1'b1, 8'h15, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, IDLE};
    vecs[2]  = '{1'b1, 8'h8A, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 2'd2, 1'b0, WAIT_GRANT};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 2'd2, 1'b0, WAIT_GRANT};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 2'd2, 1'b0, WAIT_GRANT};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 2'd2, 1'b0, WAIT_GRANT};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h42, 1'b0, 2'd2, 1'b0, FORWARD};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h15, 1'b0, 2'd2, 1'b0, FORWARD};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h8A, 1'b0, 2'd2, 1'b0, FORWARD};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'd2, 1'b1, RELEASE};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd2, 1'b0, IDLE};
    vecs[11] = '{1'b1, 8'hC1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd2, 1'b0, IDLE};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd2, 1'b0, IDLE};
    vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 2'd1, 1'b0, WAIT_GRANT};
    vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hC1, 1'b0, 2'd1, 1'b0, FORWARD};
    vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'd1, 1'b1, RELEASE};
    vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd1, 1'b0, IDLE};

    repeat (2) tick();
    rst = 1'b0;
    #1;
    check("reset readyIn", 32'(ipc_bus.readyIn), 32'd1);
    check("reset validOut", 32'(ipc_bus.validOut), 32'd0);
    check("reset dataOut", 32'(ipc_bus.dataOut), 32'd0);
    check("reset reqValid", 32'(ipc_bus.routeReserveRequestValid), 32'd0);
    check("reset reqPort", 32'(ipc_bus.routeReserveRequest), 32'd0);
    check("reset relieve", 32'(ipc_bus.routeRelieve), 32'd0);
    check("reset state", 32'(dbg.state), 32'(IDLE));
    check("reset fifo_empty", 32'(dbg.fifo_empty), 32'd1);

    // Single HEAD/BODY/TAIL packet to port 2, then a HEADTAIL to port 1.
    for (int i = 0; i < 17; i++) begin
      ipc_bus.validIn            = vecs[i].vin;
      ipc_bus.dataIn             = vecs[i].din;
      ipc_bus.readyOut           = vecs[i].rout;
      ipc_bus.routeReserveStatus = vecs[i].st;
      ipc_bus.PortReserved       = vecs[i].pr;
      #1;
      check($sformatf("vec%0d readyIn", i), 32'(ipc_bus.readyIn), 32'(vecs[i].rin));
      check($sformatf("vec%0d validOut", i), 32'(ipc_bus.validOut), 32'(vecs[i].vout));
      if (vecs[i].vout)
        check($sformatf("vec%0d dataOut", i), 32'(ipc_bus.dataOut), 32'(vecs[i].dout));
      check($sformatf("vec%0d reqValid", i), 32'(ipc_bus.routeReserveRequestValid), 32'(vecs[i].rqv));
      check($sformatf("vec%0d reqPort", i), 32'(ipc_bus.routeReserveRequest), 32'(vecs[i].rqp));
      check($sformatf("vec%0d relieve", i), 32'(ipc_bus.routeRelieve), 32'(vecs[i].rel));
      check($sformatf("vec%0d state", i), 32'(dbg.state), 32'(vecs[i].state));
      tick();
    end
    drive_idle();
    tick();

    // Back-pressure: six-flit packet to port 3 with readyOut low for 15 cycles.
    src_q = '{8'h43, 8'h01, 8'h02, 8'h03, 8'h04, 8'h85};
    exp_q = '{8'h43, 8'h01, 8'h02, 8'h03, 8'h04, 8'h85};
    run_traffic("backpressure", 0, 15, 2'd3, 0);
    check("backpressure accepted", 32'(accepted), 32'd6);
    drive_idle();
    tick();

    // Grant withheld for 20 cycles.
    src_q = '{8'h42, 8'h33, 8'hB4};
    exp_q = '{8'h42, 8'h33, 8'hB4};
    run_traffic("grant_delay", 20, 0, 2'd2, 0);
    drive_idle();
    tick();

    // Stray BODY at the head while idle is dropped; following packet to port 3.
    src_q = '{8'h2A, 8'h43, 8'h80};
    exp_q = '{8'h43, 8'h80};
    run_traffic("stray_body", 2, 0, 2'd3, 0);
    drive_idle();
    tick();

    // Asynchronous reset in the middle of forwarding.
    src_q = '{8'h40, 8'h11, 8'h12, 8'h93};
    exp_q = '{8'h40, 8'h11, 8'h12, 8'h93};
    run_traffic("pre_reset", 1, 0, 2'd0, 1);
    check("mid_packet validOut", 32'(ipc_bus.validOut), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst validOut", 32'(ipc_bus.validOut), 32'd0);
    check("async_rst reqValid", 32'(ipc_bus.routeReserveRequestValid), 32'd0);
    check("async_rst relieve", 32'(ipc_bus.routeRelieve), 32'd0);
    check("async_rst state", 32'(dbg.state), 32'(IDLE));
    check("async_rst fifo_empty", 32'(dbg.fifo_empty), 32'd1);
    check("async_rst readyIn", 32'(ipc_bus.readyIn), 32'd1);
    src_q.delete();
    exp_q.delete();
    drive_idle();
    tick();
    rst = 1'b0;
    tick();

    src_q = '{8'h41, 8'h07, 8'h8F};
    exp_q = '{8'h41, 8'h07, 8'h8F};
    run_traffic("post_reset", 3, 0, 2'd1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
